// File: rtl/vid_timing_monitor.sv
`default_nettype none
// ============================================================================
// Module      : vid_timing_monitor
// Description : Receive-side monitor for a parallel video stream
//               (vsync/hsync/dval + RGB888). Measures the frame geometry and a
//               per-frame pixel checksum, flags geometry errors and asserts
//               lock after a run of clean frames. Never back-pressures.
// Revision    : 1.0 - initial release
// ============================================================================
module vid_timing_monitor #(
    parameter int EXP_HACT    = 640,
    parameter int EXP_VACT    = 480,
    parameter int LOCK_FRAMES = 4,
    parameter int CW          = 16
) (
    input  logic          px_clk,
    input  logic          sys_rst,
    input  logic          vsync_i,
    input  logic          hsync_i,
    input  logic          dval_i,
    input  logic [7:0]    rdata_i,
    input  logic [7:0]    gdata_i,
    input  logic [7:0]    bdata_i,
    output logic          frm_done_o,
    output logic [CW-1:0] hact_o,
    output logic [CW-1:0] vact_o,
    output logic [CW-1:0] htot_o,
    output logic [31:0]   csum_o,
    output logic [2:0]    err_o,
    output logic          lock_o
);

    typedef enum logic [1:0] {
        SEEK   = 2'd0,
        ACTIVE = 2'd1,
        REPORT = 2'd2
    } state_t;

    localparam logic [CW-1:0] ONE      = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] EXP_H    = CW'(EXP_HACT);
    localparam logic [CW-1:0] EXP_V    = CW'(EXP_VACT);
    localparam logic [3:0]    LOCK_MAX = 4'(LOCK_FRAMES);

    state_t        state;
    state_t        state_nxt;
    logic          start_frame;
    logic          close_line;
    logic          do_report;

    logic          vs_d;
    logic          hs_d;
    logic          vs_rise;
    logic          vs_fall;
    logic          hs_rise;
    logic          pix_valid;

    logic [CW-1:0] line_cnt;
    logic [CW-1:0] ref_len;
    logic          have_ref;
    logic          mismatch;
    logic [CW-1:0] vact_cnt;
    logic [CW-1:0] htot_cnt;
    logic [CW-1:0] htot_cap;
    logic          hs_seen;
    logic [31:0]   csum_acc;

    logic [2:0]    err_nxt;
    logic [3:0]    lock_cnt;
    logic [3:0]    lock_cnt_nxt;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == '1) ? v : v + ONE;
    endfunction

    assign vs_rise   = vsync_i & ~vs_d;
    assign vs_fall   = ~vsync_i & vs_d;
    assign hs_rise   = hsync_i & ~hs_d;
    assign pix_valid = (state == ACTIVE) && dval_i && vsync_i;

    assign err_nxt = {vact_cnt != EXP_V, ref_len != EXP_H, mismatch};

    // Lock counter advance: clean frame counts up to the lock threshold, any error restarts
    always_comb begin
        lock_cnt_nxt = lock_cnt;
        if (err_nxt != 3'b000) begin
            lock_cnt_nxt = 4'd0;
        end else if (lock_cnt != LOCK_MAX) begin
            lock_cnt_nxt = lock_cnt + 4'd1;
        end
    end

    // Input edge-detect registers; reset high so a frame already in progress
    // when reset releases does not look like a fresh vsync rise
    always_ff @(posedge px_clk) begin
        if (sys_rst) begin
            vs_d <= 1'b1;
            hs_d <= 1'b1;
        end else begin
            vs_d <= vsync_i;
            hs_d <= hsync_i;
        end
    end

    // FSM state register
    always_ff @(posedge px_clk) begin
        if (sys_rst) begin
            state <= SEEK;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next-state and per-cycle control strobes
    always_comb begin
        state_nxt   = state;
        start_frame = 1'b0;
        close_line  = 1'b0;
        do_report   = 1'b0;
        case (state)
            SEEK: begin
                if (vs_rise) begin
                    state_nxt   = ACTIVE;
                    start_frame = 1'b1;
                end
            end
            ACTIVE: begin
                // A coincident hsync rise and vsync fall closes the line once
                close_line = hs_rise | vs_fall;
                if (vs_fall) begin
                    state_nxt = REPORT;
                end
            end
            REPORT: begin
                do_report = 1'b1;
                if (vs_rise) begin
                    state_nxt   = ACTIVE;
                    start_frame = 1'b1;
                end else begin
                    state_nxt = SEEK;
                end
            end
            default: state_nxt = SEEK;
        endcase
    end

    // Frame accumulators: line length, line count, reference length, htot, checksum
    always_ff @(posedge px_clk) begin
        if (sys_rst || start_frame) begin
            line_cnt <= '0;
            ref_len  <= '0;
            have_ref <= 1'b0;
            mismatch <= 1'b0;
            vact_cnt <= '0;
            htot_cnt <= '0;
            htot_cap <= '0;
            hs_seen  <= 1'b0;
            csum_acc <= '0;
        end else if (state == ACTIVE) begin
            if (close_line) begin
                if (line_cnt != '0) begin
                    vact_cnt <= sat_inc(vact_cnt);
                    if (!have_ref) begin
                        ref_len  <= line_cnt;
                        have_ref <= 1'b1;
                    end else if (line_cnt != ref_len) begin
                        mismatch <= 1'b1;
                    end
                end
                // A pixel on the closing edge belongs to the new line
                line_cnt <= pix_valid ? ONE : '0;
            end else if (pix_valid) begin
                line_cnt <= sat_inc(line_cnt);
            end

            if (pix_valid) begin
                csum_acc <= csum_acc + {8'h00, rdata_i, gdata_i, bdata_i};
            end

            // Counter restarts at 1 so the captured value equals the rise-to-rise period
            if (hs_rise) begin
                htot_cnt <= ONE;
                hs_seen  <= 1'b1;
                if (hs_seen) begin
                    htot_cap <= htot_cnt;
                end
            end else begin
                htot_cnt <= sat_inc(htot_cnt);
            end
        end
    end

    // Result registers, loaded once per frame in REPORT
    always_ff @(posedge px_clk) begin
        if (sys_rst) begin
            frm_done_o <= 1'b0;
            hact_o     <= '0;
            vact_o     <= '0;
            htot_o     <= '0;
            csum_o     <= '0;
            err_o      <= '0;
            lock_o     <= 1'b0;
            lock_cnt   <= 4'd0;
        end else begin
            frm_done_o <= do_report;
            if (do_report) begin
                hact_o   <= ref_len;
                vact_o   <= vact_cnt;
                htot_o   <= htot_cap;
                csum_o   <= csum_acc;
                err_o    <= err_nxt;
                lock_cnt <= lock_cnt_nxt;
                lock_o   <= (lock_cnt_nxt == LOCK_MAX);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vid_timing_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_vid_timing_monitor
// Description : Self-checking bench for vid_timing_monitor using a reduced
//               16x12 active / 20-clock line geometry. Frames come from a
//               table; expected results are queued when a frame is driven and
//               compared when frm_done_o pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vid_timing_monitor;

    localparam int EXP_HACT    = 16;
    localparam int EXP_VACT    = 12;
    localparam int LOCK_FRAMES = 4;
    localparam int CW          = 16;
    localparam int HTOT        = 20;

    logic          px_clk  = 1'b0;
    logic          sys_rst = 1'b1;
    logic          vsync_i = 1'b0;
    logic          hsync_i = 1'b0;
    logic          dval_i  = 1'b0;
    logic [7:0]    rdata_i = 8'h00;
    logic [7:0]    gdata_i = 8'h00;
    logic [7:0]    bdata_i = 8'h00;
    logic          frm_done_o;
    logic [CW-1:0] hact_o;
    logic [CW-1:0] vact_o;
    logic [CW-1:0] htot_o;
    logic [31:0]   csum_o;
    logic [2:0]    err_o;
    logic          lock_o;

    vid_timing_monitor #(
        .EXP_HACT    (EXP_HACT),
        .EXP_VACT    (EXP_VACT),
        .LOCK_FRAMES (LOCK_FRAMES),
        .CW          (CW)
    ) dut (
        .px_clk     (px_clk),
        .sys_rst    (sys_rst),
        .vsync_i    (vsync_i),
        .hsync_i    (hsync_i),
        .dval_i     (dval_i),
        .rdata_i    (rdata_i),
        .gdata_i    (gdata_i),
        .bdata_i    (bdata_i),
        .frm_done_o (frm_done_o),
        .hact_o     (hact_o),
        .vact_o     (vact_o),
        .htot_o     (htot_o),
        .csum_o     (csum_o),
        .err_o      (err_o),
        .lock_o     (lock_o)
    );

    always #5 px_clk = ~px_clk;

    // Frame recipe plus the geometry/error/lock results it must produce
    typedef struct {
        int         nl;
        int         len;
        int         sidx;
        int         slen;
        bit         empty;
        bit         coinc;
        int         pix;
        int         gap;
        logic [15:0] e_hact;
        logic [15:0] e_vact;
        logic [15:0] e_htot;
        logic [2:0]  e_err;
        logic        e_lock;
    } vec_t;

    typedef struct {
        logic [15:0] hact;
        logic [15:0] vact;
        logic [15:0] htot;
        logic [31:0] csum;
        logic [2:0]  err;
        logic        lock;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    logic [31:0] model_csum = 32'h0;

    always @(posedge px_clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input int nl, input int len, input int sidx, input int slen,
                                input bit empty, input bit coinc, input int pix, input int gap,
                                input logic [15:0] h, input logic [15:0] va, input logic [15:0] ht,
                                input logic [2:0] er, input logic lk);
        vec_t v;
        v.nl = nl; v.len = len; v.sidx = sidx; v.slen = slen;
        v.empty = empty; v.coinc = coinc; v.pix = pix; v.gap = gap;
        v.e_hact = h; v.e_vact = va; v.e_htot = ht; v.e_err = er; v.e_lock = lk;
        return v;
    endfunction

    // One input cycle, driven on the falling edge; the bench's own checksum model
    task automatic tick(input logic vs, input logic hs, input logic dv, input int pix);
        @(negedge px_clk);
        vsync_i = vs;
        hsync_i = hs;
        dval_i  = dv;
        case (pix)
            1:       begin rdata_i = 8'h01; gdata_i = 8'h00; bdata_i = 8'h00; end
            2:       begin rdata_i = 8'h00; gdata_i = 8'h00; bdata_i = 8'h01; end
            default: begin
                rdata_i = 8'($urandom_range(0, 255));
                gdata_i = 8'($urandom_range(0, 255));
                bdata_i = 8'($urandom_range(0, 255));
            end
        endcase
        if (vs && dv) model_csum = model_csum + {8'h00, rdata_i, gdata_i, bdata_i};
    endtask

    // Drive a whole frame; rst_line >= 0 pulses reset mid-line and expects no report
    task automatic drive_frame(input vec_t v, input int rst_line);
        exp_t e;
        int   nlines;
        int   ridx;
        int   len;
        int   fall;
        model_csum = 32'h0;
        nlines = v.nl + (v.empty ? 1 : 0);
        tick(1'b1, 1'b0, 1'b0, v.pix);
        tick(1'b1, 1'b0, 1'b0, v.pix);
        for (int l = 0; l < nlines; l++) begin
            ridx = v.empty ? l - 1 : l;
            if (v.empty && l == 0)   len = 0;
            else if (ridx == v.sidx) len = v.slen;
            else                     len = v.len;
            for (int c = 0; c < HTOT; c++) begin
                tick(1'b1, c < 4, (c >= 4) && (c < 4 + len), v.pix);
                if (l == rst_line && c == 6) sys_rst = 1'b1;
                if (l == rst_line && c == 7) begin
                    sys_rst = 1'b0;
                    chk("rst_mid_done", 32'(frm_done_o), 32'h0);
                    chk("rst_mid_hact", 32'(hact_o), 32'h0);
                    chk("rst_mid_vact", 32'(vact_o), 32'h0);
                    chk("rst_mid_htot", 32'(htot_o), 32'h0);
                    chk("rst_mid_csum", csum_o, 32'h0);
                    chk("rst_mid_err", 32'(err_o), 32'h0);
                    chk("rst_mid_lock", 32'(lock_o), 32'h0);
                end
            end
        end
        tick(1'b0, v.coinc, 1'b0, v.pix);
        fall = cyc;
        if (rst_line < 0) begin
            e.hact = v.e_hact; e.vact = v.e_vact; e.htot = v.e_htot;
            e.csum = model_csum; e.err = v.e_err; e.lock = v.e_lock;
            e.cyc  = fall + 2;
            sb.push_back(e);
        end
        for (int g = 1; g < v.gap; g++) tick(1'b0, 1'b0, 1'b0, v.pix);
    endtask

    // Scoreboard: every frm_done_o pulse must match the oldest queued frame
    always @(negedge px_clk) begin
        if (frm_done_o === 1'b1) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL frm_done_unexpected: got pulse expected none (t=%0t)", $time);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("done_latency", 32'(cyc), 32'(e.cyc));
                chk("hact", 32'(hact_o), 32'(e.hact));
                chk("vact", 32'(vact_o), 32'(e.vact));
                chk("htot", 32'(htot_o), 32'(e.htot));
                chk("csum", csum_o, e.csum);
                chk("err", 32'(err_o), 32'(e.err));
                chk("lock", 32'(lock_o), 32'(e.lock));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t tbl[13];
        vec_t clean;
        //            nl  len sidx slen emp coi pix gap  hact vact htot  err     lock
        tbl[0]  = mk(12, 16, -1,  0,  0,  0,  0,  6,  16,  12,  20, 3'b000, 1'b0);
        tbl[1]  = mk(12, 16, -1,  0,  0,  0,  0,  6,  16,  12,  20, 3'b000, 1'b0);
        tbl[2]  = mk(12, 16, -1,  0,  0,  0,  0,  6,  16,  12,  20, 3'b000, 1'b0);
        tbl[3]  = mk(12, 16, -1,  0,  0,  0,  0,  1,  16,  12,  20, 3'b000, 1'b1);
        tbl[4]  = mk(12, 16, -1,  0,  0,  0,  0,  6,  16,  12,  20, 3'b000, 1'b1);
        tbl[5]  = mk(12, 16,  3, 15,  0,  0,  0,  6,  16,  12,  20, 3'b001, 1'b0);
        tbl[6]  = mk(12, 16, -1,  0,  1,  0,  0,  6,  16,  12,  20, 3'b000, 1'b0);
        tbl[7]  = mk(11, 16, -1,  0,  0,  0,  0,  6,  16,  11,  20, 3'b100, 1'b0);
        tbl[8]  = mk(12, 16, -1,  0,  0,  1,  0,  6,  16,  12,  20, 3'b000, 1'b0);
        tbl[9]  = mk(12, 15, -1,  0,  0,  0,  0,  6,  15,  12,  20, 3'b010, 1'b0);
        tbl[10] = mk(12, 16, -1,  0,  0,  0,  1,  6,  16,  12,  20, 3'b000, 1'b0);
        tbl[11] = mk(12, 16, -1,  0,  0,  0,  2,  6,  16,  12,  20, 3'b000, 1'b0);
        tbl[12] = mk( 1, 16, -1,  0,  0,  0,  0,  6,  16,   1,   0, 3'b100, 1'b0);

        // Reset held while a frame is already running
        for (int c = 0; c < 8; c++) tick(1'b1, c < 4, c >= 4, 0);
        chk("reset_done", 32'(frm_done_o), 32'h0);
        chk("reset_hact", 32'(hact_o), 32'h0);
        chk("reset_vact", 32'(vact_o), 32'h0);
        chk("reset_htot", 32'(htot_o), 32'h0);
        chk("reset_csum", csum_o, 32'h0);
        chk("reset_err", 32'(err_o), 32'h0);
        chk("reset_lock", 32'(lock_o), 32'h0);
        sys_rst = 1'b0;
        // Remainder of that partial frame must be ignored
        for (int l = 0; l < 2; l++)
            for (int c = 0; c < HTOT; c++) tick(1'b1, c < 4, c >= 4, 0);
        for (int c = 0; c < 6; c++) tick(1'b0, 1'b0, 1'b0, 0);

        for (int i = 0; i < 13; i++) drive_frame(tbl[i], -1);

        // One-cycle reset in the middle of a frame: no report for it
        clean = mk(12, 16, -1, 0, 0, 0, 0, 6, 16, 12, 20, 3'b000, 1'b0);
        drive_frame(clean, 2);

        // Lock has to be re-earned from zero after that reset
        for (int i = 0; i < 4; i++) begin
            clean.e_lock = (i == 3);
            drive_frame(clean, -1);
        end

        for (int c = 0; c < 10; c++) tick(1'b0, 1'b0, 1'b0, 0);
        chk("scoreboard_drained", 32'(sb.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
